cmp_hysteresis_monitor: RTL
===========================

Name: cmp_hysteresis_monitor

Overview:
- Sequential stage directly downstream of the n-bit magnitude comparator.
- Consumes the comparator's one-hot equal/greater/less flags, one sample per valid cycle.
- Produces a debounced, hysteretic alarm (asserts on sustained A>B, deasserts on sustained A<B), per-outcome event counters and a protocol-error flag.
- Used wherever a threshold comparison must not chatter, e.g. a level or limit monitor.

Parameters:
- ASSERT_CNT, 4: consecutive accepted greater samples needed to raise alarm; legal range 1..255.
- DEASSERT_CNT, 4: consecutive accepted less samples needed to drop alarm; legal range 1..255.
- CNT_W, 16: width of each saturating event counter; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  comparator flags are a sample this cycle; block is always ready, with no backpressure.
- equal  in  1  comparator A==B.
- greater  in  1  comparator A>B.
- less  in  1  comparator A<B.
- clear  in  1  synchronous clear of FSM, counters and error flag.
- alarm  out  1  registered hysteretic alarm level.
- alarm_rise  out  1  one-cycle pulse on alarm 0->1.
- alarm_fall  out  1  one-cycle pulse on alarm 1->0.
- gt_cnt  out  CNT_W  accepted greater samples, saturating.
- lt_cnt  out  CNT_W  accepted less samples, saturating.
- eq_cnt  out  CNT_W  accepted equal samples, saturating.
- onehot_err  out  1  sticky: a valid sample had flags not exactly one-hot.

Behaviour:
- Reset (rst_n=0, async): FSM=NORMAL, run=0, alarm=0, alarm_rise=0, alarm_fall=0, all counters=0, onehot_err=0.
- Accepted sample: in_valid=1 AND exactly one flag high.
- Invalid sample: in_valid=1 with 0, 2 or 3 flags high.
  - Sets onehot_err.
  - FSM, run and counters hold.
- in_valid=0: everything holds; pulses are 0.
- run counter: 8 bits internal.
- FSM states and transitions (accepted samples only):
  - NORMAL:
    - greater with ASSERT_CNT==1 -> ALARM, pulse alarm_rise.
    - greater otherwise -> PEND_HI, run=1.
    - equal/less -> stay.
  - PEND_HI:
    - greater with run+1==ASSERT_CNT -> ALARM, run=0, pulse alarm_rise.
    - greater otherwise -> run+1.
    - equal/less -> NORMAL, run=0.
  - ALARM:
    - less with DEASSERT_CNT==1 -> NORMAL, pulse alarm_fall.
    - less otherwise -> PEND_LO, run=1.
    - greater/equal -> stay.
  - PEND_LO:
    - less with run+1==DEASSERT_CNT -> NORMAL, run=0, pulse alarm_fall.
    - less otherwise -> run+1.
    - greater/equal -> ALARM, run=0.
- alarm = 1 in ALARM and PEND_LO, 0 in NORMAL and PEND_HI. It is registered.
- Latency: alarm and alarm_rise rise at the clock edge that accepts the ASSERT_CNT-th consecutive greater sample. They are visible the cycle after that sample is presented. alarm_fall behaves symmetrically.
- alarm_rise and alarm_fall are never high together. Each is high for exactly one cycle.
- Counters:
  - Each accepted sample increments exactly one counter.
  - A counter at 2^CNT_W-1 holds (saturates, no wrap).
- clear=1 (synchronous) has priority over a same-cycle sample:
  - FSM=NORMAL, run=0, alarm=0.
  - Counters=0, onehot_err=0.
  - No alarm_fall pulse, even if alarm was 1.
  - The same-cycle sample is discarded.
- onehot_err clears only via clear or rst_n.
- Reset mid-run (e.g. in PEND_HI or PEND_LO): immediate return to reset values; no pulse generated.
- Gaps of in_valid=0 do not break a consecutive run; only accepted samples of another kind do.

Test Plan:
- Default params; rst_n released; 4 consecutive valid greater -> alarm=1 and alarm_rise=1 for one cycle after the 4th sample; gt_cnt=4.
- 3 greater, 1 equal, 3 greater -> alarm stays 0; FSM ends in PEND_HI with run=3; gt_cnt=6, eq_cnt=1.
- In ALARM: 3 less, 1 greater, 4 less -> alarm stays 1 until the 4th less of the second run, then alarm=0 with alarm_fall pulse; lt_cnt=7.
- Valid sample with greater=less=1 -> onehot_err=1 sticky; no counter or FSM change; later clear -> onehot_err=0.
- CNT_W=3; 10 equal samples -> eq_cnt=7 (saturated). ASSERT_CNT=1: single greater -> immediate ALARM and rise pulse.
- In ALARM, clear and valid less in the same cycle -> alarm=0, lt_cnt=0, no alarm_fall. rst_n pulsed low mid-PEND_HI -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cmp_hysteresis_monitor.sv
// Hysteretic, debounced alarm on the one-hot flags of a magnitude comparator,
// with saturating per-outcome event counters and a sticky protocol-error flag.
module cmp_hysteresis_monitor #(
    parameter int unsigned ASSERT_CNT   = 4,
    parameter int unsigned DEASSERT_CNT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             equal,
    input  logic             greater,
    input  logic             less,
    input  logic             clear,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic             onehot_err
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_ALARM   = 2'd2,
        ST_PEND_LO = 2'd3
    } state_t;

    localparam logic [7:0] ASSERT_RUN   = 8'(ASSERT_CNT);
    localparam logic [7:0] DEASSERT_RUN = 8'(DEASSERT_CNT);

    state_t             state_q, state_d;
    logic [7:0]         run_q, run_d;
    logic               alarm_q, alarm_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic [CNT_W-1:0]   gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0]   lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0]   eq_cnt_q, eq_cnt_d;
    logic               err_q, err_d;

    logic               one_hot;
    logic               accepted;
    logic               invalid;
    logic [7:0]         run_inc;

    assign one_hot  = (equal & ~greater & ~less) |
                      (~equal & greater & ~less) |
                      (~equal & ~greater & less);
    assign accepted = in_valid & one_hot;
    assign invalid  = in_valid & ~one_hot;
    assign run_inc  = run_q + 8'd1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a combinational output unassigned and no latch is inferred.
        state_d  = state_q;
        run_d    = run_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        gt_cnt_d = gt_cnt_q;
        lt_cnt_d = lt_cnt_q;
        eq_cnt_d = eq_cnt_q;
        err_d    = err_q;

        if (clear) begin
            state_d  = ST_NORMAL;
            run_d    = 8'd0;
            gt_cnt_d = '0;
            lt_cnt_d = '0;
            eq_cnt_d = '0;
            err_d    = 1'b0;
        end else if (accepted) begin
            if (greater) gt_cnt_d = sat_inc(gt_cnt_q);
            if (less)    lt_cnt_d = sat_inc(lt_cnt_q);
            if (equal)   eq_cnt_d = sat_inc(eq_cnt_q);

            unique case (state_q)
                ST_NORMAL: begin
                    if (greater) begin
                        if (ASSERT_RUN == 8'd1) begin
                            state_d = ST_ALARM;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ST_PEND_HI;
                            run_d   = 8'd1;
                        end
                    end
                end
                ST_PEND_HI: begin
                    if (greater) begin
                        if (run_inc == ASSERT_RUN) begin
                            state_d = ST_ALARM;
                            run_d   = 8'd0;
                            rise_d  = 1'b1;
                        end else begin
                            run_d   = run_inc;
                        end
                    end else begin
                        state_d = ST_NORMAL;
                        run_d   = 8'd0;
                    end
                end
                ST_ALARM: begin
                    if (less) begin
                        if (DEASSERT_RUN == 8'd1) begin
                            state_d = ST_NORMAL;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = ST_PEND_LO;
                            run_d   = 8'd1;
                        end
                    end
                end
                ST_PEND_LO: begin
                    if (less) begin
                        if (run_inc == DEASSERT_RUN) begin
                            state_d = ST_NORMAL;
                            run_d   = 8'd0;
                            fall_d  = 1'b1;
                        end else begin
                            run_d   = run_inc;
                        end
                    end else begin
                        state_d = ST_ALARM;
                        run_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    run_d   = 8'd0;
                end
            endcase
        end else if (invalid) begin
            err_d = 1'b1;
        end

        // Alarm level is a pure function of the next state, then registered.
        alarm_d = (state_d == ST_ALARM) || (state_d == ST_PEND_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_NORMAL;
            run_q    <= 8'd0;
            alarm_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            gt_cnt_q <= '0;
            lt_cnt_q <= '0;
            eq_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            run_q    <= run_d;
            alarm_q  <= alarm_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            gt_cnt_q <= gt_cnt_d;
            lt_cnt_q <= lt_cnt_d;
            eq_cnt_q <= eq_cnt_d;
            err_q    <= err_d;
        end
    end

    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;
    assign alarm_fall = fall_q;
    assign gt_cnt     = gt_cnt_q;
    assign lt_cnt     = lt_cnt_q;
    assign eq_cnt     = eq_cnt_q;
    assign onehot_err = err_q;

endmodule
